// File: rtl/spi_ram_burst_pkg.sv
// spi_ram_pkg: shared command/state encodings and default parameter constants
// for the spi_ram_burst block and its storage sub-module.
package spi_ram_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_MEM_DEPTH = 256;
  localparam int unsigned CMD_W         = 2;

  // Command tag carried in the top two bits of each SPI word.
  typedef enum logic [CMD_W-1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  // Single mode register: at most one of write/read address is armed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WADDR = 2'd1,
    RADDR = 2'd2
  } state_e;

endpackage

// File: rtl/spi_ram_storage.sv
// spi_ram_storage: MEM_DEPTH x DATA_W word store, synchronous write port and
// registered read port; contents and read register are not reset.
// Ports: clk; we/waddr/wdata write port; re/raddr read enable and address;
//        rdata registered read data (updates only when re is high).
module spi_ram_storage #(
  parameter int unsigned DATA_W    = spi_ram_pkg::DEF_DATA_W,
  parameter int unsigned MEM_DEPTH = spi_ram_pkg::DEF_MEM_DEPTH,
  localparam int unsigned AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: decodes command-tagged SPI words, writes/reads a word RAM
// and returns read data for serialisation.
// Ports: clk, rst (sync, active high); rx_valid/din command input
//        (din[DATA_W+1:DATA_W] = command, din[DATA_W-1:0] = payload);
//        dout read data, tx_valid one-cycle new-data pulse, cmd_err one-cycle
//        pulse on an illegal command or out-of-range address.
// Option: define SPI_RAM_BURST_AUTO_INC_EN to auto-increment the write/read
//         address (wrapping at MEM_DEPTH-1) after each accepted data command.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              cmd_err
);

  localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              tx_valid_q, tx_valid_d;
  logic              cmd_err_q, cmd_err_d;
  logic              dout_vld_q, dout_vld_d;
  logic              we_c, re_c;
  logic [DATA_W-1:0] rd_data;

  cmd_e              cmd_c;
  logic [ADDR_W-1:0] addr_c;
  logic              in_range_c;

  assign cmd_c      = cmd_e'(din[DATA_W+1:DATA_W]);
  assign addr_c     = din[ADDR_W-1:0];
  assign in_range_c = 32'(addr_c) < MEM_DEPTH;

`ifdef SPI_RAM_BURST_AUTO_INC_EN
  // Burst step wraps at the last real location, not at 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction
`endif

  // Command decode and next-state logic.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    dout_vld_d = dout_vld_q;
    we_c       = 1'b0;
    re_c       = 1'b0;
    if (rx_valid) begin
      unique case (cmd_c)
        WR_ADDR: begin
          if (in_range_c) begin
            wr_addr_d = addr_c;
            state_d   = WADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        WR_DATA: begin
          if (state_q == WADDR) begin
            we_c = 1'b1;
`ifdef SPI_RAM_BURST_AUTO_INC_EN
            wr_addr_d = addr_inc(wr_addr_q);
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        RD_ADDR: begin
          if (in_range_c) begin
            rd_addr_d = addr_c;
            state_d   = RADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        RD_DATA: begin
          if (state_q == RADDR) begin
            re_c       = 1'b1;
            tx_valid_d = 1'b1;
            dout_vld_d = 1'b1;
`ifdef SPI_RAM_BURST_AUTO_INC_EN
            rd_addr_d = addr_inc(rd_addr_q);
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end
    // Reset blocks any memory access at the same edge.
    if (rst) begin
      we_c = 1'b0;
      re_c = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  spi_ram_storage #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (we_c),
    .waddr (wr_addr_q[MEM_AW-1:0]),
    .wdata (din[DATA_W-1:0]),
    .re    (re_c),
    .raddr (rd_addr_q[MEM_AW-1:0]),
    .rdata (rd_data)
  );

  // The un-reset read register is masked to zero until the first read.
  assign dout     = dout_vld_q ? rd_data : '0;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised successor of the SPI slave's RAM block: decodes 2-bit command-tagged words from the SPI serial-to-parallel stage, stores and returns data words, and hands read data back for serialisation. Generalises data/address width and depth. Adds a command-sequencing state machine with an error flag and optional burst (auto-increment) addressing. Sits between the SPI slave FSM (`rx_valid`/`din`) and its shift-out path (`tx_valid`/`dout`).

## Interface

- `DATA_W`, default 8: data word width. Constraint: `ADDR_W <= DATA_W`.
- `ADDR_W`, default 8: address width.
- `MEM_DEPTH`, default 256: number of words. Constraint: `MEM_DEPTH <= 2**ADDR_W`.

Ports:

- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx_valid`, input, 1: `din` is valid this cycle.
- `din`, input, `DATA_W+2`: `din[DATA_W+1:DATA_W]` = command; `din[DATA_W-1:0]` = payload.
- `dout`, output, `DATA_W`: read data. Holds its last value between reads.
- `tx_valid`, output, 1: one-cycle pulse, `dout` is new.
- `cmd_err`, output, 1: one-cycle pulse on an illegal command or an out-of-range address.

## Operation

- Commands:
  - 00 `WR_ADDR`: latch write address from `din[ADDR_W-1:0]`.
  - 01 `WR_DATA`: write `din[DATA_W-1:0]` to the write address.
  - 10 `RD_ADDR`: latch read address.
  - 11 `RD_DATA`: read from the read address; payload is ignored.
- States: `IDLE`, `WADDR`, `RADDR`. Commands are acted on only when `rx_valid`=1. With `rx_valid`=0, nothing changes.
- `WR_ADDR`:
  - Address < `MEM_DEPTH`: latch `wr_addr`, go to `WADDR`.
  - Otherwise: pulse `cmd_err`; `wr_addr` and state are unchanged.
- `RD_ADDR`: same rule, latching `rd_addr` and going to `RADDR`.
- `WR_DATA`:
  - In `WADDR`: write the memory. State stays `WADDR`, so repeated writes are legal.
  - Any other state: pulse `cmd_err`, no write.
- `RD_DATA`:
  - In `RADDR`: `dout` <= `mem[rd_addr]`, `tx_valid` pulses. State stays `RADDR`.
  - Any other state: pulse `cmd_err`; `dout` is unchanged and `tx_valid` stays 0.
- A new `WR_ADDR` or `RD_ADDR` in any state replaces the current mode. There is a single mode register, so a write address and a read address are never armed together.
- Address arithmetic is unsigned. Burst increment wraps `MEM_DEPTH-1` -> 0 (not at `2**ADDR_W`).
- Memory contents are not reset.
- Reset values: `dout`=0, `tx_valid`=0, `cmd_err`=0, state=`IDLE`, `wr_addr`=0, `rd_addr`=0.

## Timing

- The write is complete at the clock edge that samples `WR_DATA`. A read of the same address in the very next cycle returns the new data.
- Read latency: `RD_DATA` sampled at edge N -> `dout` valid and `tx_valid`=1 in the cycle after edge N, for exactly one cycle.
- `cmd_err` is registered: it is high for the single cycle after the offending sample.
- Back-to-back `rx_valid` is supported every cycle. N consecutive `RD_DATA` give N consecutive `tx_valid` pulses.
- `rst` high at an edge overrides `rx_valid`: no memory write, all outputs go to their reset values, state goes to `IDLE`. A read in flight is dropped; no `tx_valid` follows.

## Configuration

- `SPI_RAM_BURST_AUTO_INC_EN` defined:
  - After each accepted `WR_DATA`, `wr_addr` increments (with wrap).
  - After each accepted `RD_DATA`, `rd_addr` increments (with wrap).
- Not defined: addresses hold. Repeated data commands hit the same location, matching the legacy single-access behaviour.

## Structure

- Package `spi_ram_pkg` holds:
  - `cmd_e` enum: `WR_ADDR`=2'b00, `WR_DATA`=2'b01, `RD_ADDR`=2'b10, `RD_DATA`=2'b11.
  - `state_e` enum: `IDLE`, `WADDR`, `RADDR`.
  - Default parameter constants.
- Sub-module `spi_ram_storage` (parameters `DATA_W`, `MEM_DEPTH`): synchronous write port, registered read port, no reset.
- The top level holds the FSM, the address registers, range checks and the output registers.

## Test plan

- Reset, then `WR_ADDR` 0x10, `WR_DATA` 0xA5, `RD_ADDR` 0x10, `RD_DATA` -> one cycle after `RD_DATA`: `dout`=0xA5, `tx_valid`=1 for exactly one cycle; `cmd_err` never asserts.
- After reset, `WR_DATA` 0x33 with no address, then `RD_DATA` -> `cmd_err` pulses after each command, `tx_valid` stays 0, and location 0 is unmodified.
- With `MEM_DEPTH`=200: `WR_ADDR` 0xC8 -> `cmd_err`=1 and state unchanged. Then `WR_ADDR` 0xC7, `WR_DATA` x3 (0x01, 0x02, 0x03):
  - With the macro: locations 0xC7, 0x00, 0x01 hold 0x01, 0x02, 0x03 (wrap).
  - Without the macro: 0xC7 holds 0x03.
- `RD_ADDR` 0x05, then 4 back-to-back `RD_DATA` -> 4 consecutive `tx_valid` pulses:
  - With the macro: contents of 0x05..0x08 in order.
  - Without the macro: 0x05 repeated.
- `rst`=1 in the same cycle as `RD_DATA` -> no `tx_valid`, `dout`=0, and a following `WR_DATA` flags `cmd_err` (state is `IDLE`).
- `rx_valid`=0 with random `din` for 50 cycles -> no output change and no memory change.
